// File: rtl/seq_detector_1001.sv
// Moore-style detector for the serial pattern 1001 (first bit 1), with selectable
// overlapping detection, a registered match pulse and a saturating match counter.
module seq_detector_1001 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sin,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S100  = 3'd3,
        S1001 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      if (en) state_d = sin ? S1 : S0;
            S1:      if (en) state_d = sin ? S1 : S10;
            S10:     if (en) state_d = sin ? S1 : S100;
            S100:    if (en) state_d = sin ? S1001 : S0;
            // Overlapping mode reuses the trailing "10" as a new prefix.
            S1001:   if (en) state_d = sin ? S1 : (overlap ? S10 : S0);
            default: state_d = S0;
        endcase
    end

    always_comb begin
        match_d = en && (state_d == S1001);
    end

    always_comb begin
        count_d = count_q;
        if (clr_cnt) begin
            count_d = match_d ? CNT_W'(1) : '0;
        end else if (match_d && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
        sat_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
            match_q <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign match = match_q;
    assign state = state_q;
    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_1001.sv
// Directed bench for seq_detector_1001: default 8-bit counter instance plus a
// 3-bit counter instance sharing the same stimulus for the saturation cases.
module tb_seq_detector_1001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       sin = 1'b0;
    logic       overlap = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       match, match_s;
    logic [2:0] state, state_s;
    logic [7:0] count;
    logic [2:0] count_s;
    logic       sat, sat_s;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    seq_detector_1001 dut (
        .clk(clk), .reset(reset), .en(en), .sin(sin), .overlap(overlap),
        .clr_cnt(clr_cnt), .match(match), .state(state), .count(count), .sat(sat)
    );

    seq_detector_1001 #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .en(en), .sin(sin), .overlap(overlap),
        .clr_cnt(clr_cnt), .match(match_s), .state(state_s), .count(count_s), .sat(sat_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample, let one rising edge pass, settle 1 ns after it.
    task automatic step(input logic s, input logic e);
        sin = s;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0;
        clr_cnt = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic send_pattern();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
    endtask

    logic [6:0] ov_stream = 7'b1001001;

    initial begin
        // Reset state
        step(1'b0, 1'b0);
        check("rst_state", state, 0);
        check("rst_match", match, 0);
        check("rst_count", count, 0);
        check("rst_sat", sat, 0);
        reset = 1'b0;

        // Reset mid-pattern
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("pre_rst_s100", state, 3);
        reset = 1'b1;
        sin = 1'b1;
        en = 1'b1;
        #2;
        check("async_rst_state", state, 0);
        #10;
        check("rst_hold_state", state, 0);
        check("rst_hold_match", match, 0);
        check("rst_hold_count", count, 0);
        #1;
        reset = 1'b0;
        send_pattern();
        check("post_rst_match", match, 1);
        check("post_rst_count", count, 1);
        check("post_rst_state", state, 4);
        step(1'b0, 1'b0);
        check("post_rst_pulse_end", match, 0);

        // Repeating 1001 stream, both modes
        for (int m = 0; m < 2; m++) begin
            do_reset();
            overlap = (m == 0);
            for (int i = 0; i < 16; i++) begin
                step((i % 4 == 0) || (i % 4 == 3), 1'b1);
                check("rep_match", match, (i % 4 == 3) ? 1 : 0);
            end
            check("rep_count", count, 4);
        end

        // Overlap behaviour on 1001001
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(ov_stream[6-i], 1'b1);
            check("ov1_match", match, (i == 3 || i == 6) ? 1 : 0);
        end
        check("ov1_count", count, 2);
        check("ov1_state", state, 4);
        do_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(ov_stream[6-i], 1'b1);
            check("ov0_match", match, (i == 3) ? 1 : 0);
        end
        check("ov0_count", count, 1);
        check("ov0_state", state, 1);

        // Stall with en=0
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(i[0] ? 1'b0 : 1'b1, 1'b0);
            check("stall_state", state, 3);
            check("stall_match", match, 0);
        end
        step(1'b1, 1'b1);
        check("stall_match_hit", match, 1);
        check("stall_state_hit", state, 4);
        check("stall_count", count, 1);
        step(1'b1, 1'b0);
        check("hold_no_repulse", match, 0);
        check("hold_state", state, 4);
        step(1'b0, 1'b0);
        check("hold_no_repulse2", match, 0);

        // Saturation on the 3-bit instance
        do_reset();
        overlap = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            send_pattern();
            check("sat_count_s", count_s, (k < 7) ? k : 7);
            check("sat_flag_s", sat_s, (k >= 7) ? 1 : 0);
            check("sat_count_wide", count, k);
        end
        check("sat_flag_wide", sat, 0);
        clr_cnt = 1'b1;
        step(1'b0, 1'b0);
        clr_cnt = 1'b0;
        check("clr_sat_count_s", count_s, 0);
        check("clr_sat_flag_s", sat_s, 0);

        // Clear colliding with a match
        do_reset();
        for (int k = 0; k < 5; k++) send_pattern();
        check("pre_clr_count", count, 5);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        check("clr_collide_count", count, 1);
        check("clr_collide_match", match, 1);
        check("clr_collide_state", state, 4);
        step(1'b0, 1'b0);
        clr_cnt = 1'b0;
        check("clr_alone_count", count, 0);
        check("clr_alone_sat", sat, 0);
        check("clr_alone_state", state, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detector_1001.md
Name: seq_detector_1001

Overview:
- Serial consumer that sits directly downstream of the 4-bit shift register and samples its `sout` bit stream.
- A Moore-style FSM detects the pattern 1001, MSB first (first bit received is 1), with selectable overlapping or non-overlapping detection.
- Each detection produces a one-cycle `match` pulse and increments a saturating match counter.
- Feeds the FSM lab's status and LED logic.

Parameters:
- CNT_W, 8, width of the match counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample qualifier; `sin` is consumed only on a rising edge with en=1.
- sin  input  1  serial data in, connected to upstream `sout`.
- overlap  input  1  1 = overlapping detection; 0 = restart after each match. Sampled together with `sin`.
- clr_cnt  input  1  synchronous clear of the match counter.
- match  output  1  registered one-cycle pulse per detected 1001.
- state  output  3  current FSM state code, for debug.
- count  output  CNT_W  number of matches since reset or clear.
- sat  output  1  high while count == 2^CNT_W-1.

Behaviour:
- Reset (async, active-high), applied immediately and held while reset=1:
  - state = S0
  - match = 0
  - count = 0
  - sat = 0
- Reset asserted mid-pattern discards partial progress; the first bit after release is treated as bit 1 of a new pattern.
- State codes:
  - S0 = 3'd0, nothing matched
  - S1 = 3'd1, "1"
  - S10 = 3'd2, "10"
  - S100 = 3'd3, "100"
  - S1001 = 3'd4, full match
  - Codes 5-7 are illegal and go to S0 on the next edge, regardless of `en`.
- Transitions apply only on an edge with en=1; with en=0 the state holds.
  - S0: sin=1 -> S1; sin=0 -> S0
  - S1: sin=0 -> S10; sin=1 -> S1
  - S10: sin=0 -> S100; sin=1 -> S1
  - S100: sin=1 -> S1001; sin=0 -> S0
  - S1001, overlap=1: sin=1 -> S1; sin=0 -> S10 (the suffix "10" is reused)
  - S1001, overlap=0: sin=1 -> S1; sin=0 -> S0
- `match`:
  - Next value is (en && next_state == S1001); it is registered.
  - It rises on the same edge that enters S1001 and is high for exactly one cycle.
  - Holding in S1001 with en=0 does not re-pulse `match`.
  - Latency: the edge that samples the 4th pattern bit drives `match` high, visible in the following cycle.
- Counter, evaluated each edge:
  - clr_cnt=1 and match-next=1 together -> count = 1.
  - clr_cnt=1 alone -> count = 0.
  - match-next=1 with count < max -> count + 1.
  - match-next=1 at max -> hold at max; no wrap.
  - `sat` is a registered decode of count == max, updated in the same edge as count.
- `clr_cnt` affects neither the FSM nor `match`.
- `overlap` may change at any time; its value at the edge when state is S1001 decides the fallback.

Test Plan:
- Reset mid-stream: drive reset=1 for 13 ns while in S100, then send sin=1 -> state = 0, match stays 0, count = 0; after release, sin 1,0,0,1 with en=1 -> one match pulse, count = 1.
- Repeating upstream stream 1,0,0,1,1,0,0,1,... with en=1 for 16 bits, overlap=1 -> match every 4th sample, count = 4; repeat with overlap=0 -> count = 4.
- Overlap check, stream 1,0,0,1,0,0,1:
  - overlap=1 -> matches after bits 4 and 7, count = 2.
  - overlap=0 -> match after bit 4 only, count = 1, final state = S1.
- Stall: stream 1,0,0 then en=0 for 5 cycles with sin toggling, then en=1 with sin=1 -> state holds at 3 during the stall, then a single match and state = 4; en=0 afterwards keeps match = 0.
- Saturation, CNT_W=3: 9 back-to-back patterns -> count climbs to 7, sat = 1 from the 7th match, count stays 7.
- Clear collision: clr_cnt=1 on the same edge a match is detected with count = 5 -> count = 1; clr_cnt alone -> count = 0, sat = 0.
